pmux_pipe: RTL and testbench

- Parametrised, registered N:1 word multiplexer with a valid/ready handshake on both sides.
- Two selection modes:
  - Indexed: grouped select codes, several codes per channel.
  - Priority: lowest-index request wins.
- Sits between datapath producers and a single consumer.
- Next-generation replacement for the fixed 8:1 and 4:1 bit muxes.

---
 rtl/pmux_pipe_if.sv | 31 +++
 rtl/pmux_pipe.sv | 134 +++++++++++++
 tb/tb_pmux_pipe.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pmux_pipe_if.sv
// Handshake and data bundle for pmux_pipe: producer-side request plus consumer-side result.
// The slave modport is the mux's view; master is the driving environment's view.
interface pmux_pipe_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 4
);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      in_valid;
  logic                      in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       req;
  logic [CHANNELS*WIDTH-1:0] d;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          y;
  logic [CHAN_W-1:0]         y_chan;
  logic                      miss;

  modport slave (
    input  in_valid, mode, sel, req, d, out_ready,
    output in_ready, out_valid, y, y_chan, miss
  );

  modport master (
    output in_valid, mode, sel, req, d, out_ready,
    input  in_ready, out_valid, y, y_chan, miss
  );
endinterface

// File: rtl/pmux_pipe.sv
// Registered N:1 word mux with valid/ready on both sides; indexed (grouped codes) or priority select.
// Optional PMUX_PIPE_STATS_EN adds saturating accept/miss counters (acc_cnt, miss_cnt).
module pmux_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 4,
  parameter int GROUP    = 2
) (
  input  logic        clk,
  input  logic        rst,
  pmux_pipe_if.slave  bus
`ifdef PMUX_PIPE_STATS_EN
  ,
  output logic [15:0] acc_cnt,
  output logic [15:0] miss_cnt
`endif
);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SHIFT  = $clog2(GROUP);

  logic                accept_s;
  logic [31:0]         code_chan_s;
  logic                idx_hit_s;
  logic [WIDTH-1:0]    idx_y_s;
  logic [CHAN_W-1:0]   idx_chan_s;
  logic [CHANNELS-1:0] grant_s;
  logic [WIDTH-1:0]    pri_y_s;
  logic [CHAN_W-1:0]   pri_chan_s;
  logic                pri_miss_s;
  logic [WIDTH-1:0]    nxt_y_s;
  logic [CHAN_W-1:0]   nxt_chan_s;
  logic                nxt_miss_s;

  logic                out_valid_r;
  logic [WIDTH-1:0]    y_r;
  logic [CHAN_W-1:0]   y_chan_r;
  logic                miss_r;

  assign accept_s     = bus.in_valid && bus.in_ready;
  assign bus.in_ready = !out_valid_r || bus.out_ready;
  assign bus.out_valid = out_valid_r;
  assign bus.y         = y_r;
  assign bus.y_chan    = y_chan_r;
  assign bus.miss      = miss_r;

  // Indexed decode: AND-OR mux so unmapped codes yield all-zero data and channel.
  always_comb begin
    code_chan_s = {{(32-SEL_W){1'b0}}, bus.sel} >> SHIFT;
    idx_hit_s   = (code_chan_s < 32'(CHANNELS));
    idx_y_s     = {WIDTH{1'b0}};
    idx_chan_s  = {CHAN_W{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      idx_y_s    = idx_y_s | ({WIDTH{code_chan_s == 32'(i)}} & bus.d[i*WIDTH +: WIDTH]);
      idx_chan_s = idx_chan_s | ((code_chan_s == 32'(i)) ? CHAN_W'(i) : {CHAN_W{1'b0}});
    end
  end

  // Priority decode: req & -req isolates the lowest set bit as a one-hot grant.
  always_comb begin
    grant_s    = bus.req & (~bus.req + {{(CHANNELS-1){1'b0}}, 1'b1});
    pri_miss_s = ~|bus.req;
    pri_y_s    = {WIDTH{1'b0}};
    pri_chan_s = {CHAN_W{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      pri_y_s    = pri_y_s | ({WIDTH{grant_s[i]}} & bus.d[i*WIDTH +: WIDTH]);
      pri_chan_s = pri_chan_s | (grant_s[i] ? CHAN_W'(i) : {CHAN_W{1'b0}});
    end
  end

  // Mode select for the result to be loaded on accept.
  always_comb begin
    nxt_y_s    = {WIDTH{1'b0}};
    nxt_chan_s = {CHAN_W{1'b0}};
    nxt_miss_s = 1'b0;
    if (bus.mode) begin
      nxt_y_s    = pri_y_s;
      nxt_chan_s = pri_chan_s;
      nxt_miss_s = pri_miss_s;
    end else begin
      nxt_y_s    = idx_y_s;
      nxt_chan_s = idx_chan_s;
      nxt_miss_s = !idx_hit_s;
    end
  end

  // Output stage: load on accept, drop valid on consume, freeze under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      y_r         <= {WIDTH{1'b0}};
      y_chan_r    <= {CHAN_W{1'b0}};
      miss_r      <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      y_r         <= nxt_y_s;
      y_chan_r    <= nxt_chan_s;
      miss_r      <= nxt_miss_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

`ifdef PMUX_PIPE_STATS_EN
  logic [15:0] acc_cnt_r;
  logic [15:0] miss_cnt_r;

  assign acc_cnt  = acc_cnt_r;
  assign miss_cnt = miss_cnt_r;

  // Saturating transaction and miss counters, stepped on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt_r  <= 16'h0000;
      miss_cnt_r <= 16'h0000;
    end else if (accept_s) begin
      if (acc_cnt_r != 16'hFFFF) begin
        acc_cnt_r <= acc_cnt_r + 16'h0001;
      end else begin
        acc_cnt_r <= acc_cnt_r;
      end
      if (nxt_miss_s && (miss_cnt_r != 16'hFFFF)) begin
        miss_cnt_r <= miss_cnt_r + 16'h0001;
      end else begin
        miss_cnt_r <= miss_cnt_r;
      end
    end else begin
      acc_cnt_r  <= acc_cnt_r;
      miss_cnt_r <= miss_cnt_r;
    end
  end
`endif
endmodule

// File: tb/tb_pmux_pipe.sv
// Directed self-checking bench for pmux_pipe: 8-channel and 6-channel instances.
module tb_pmux_pipe;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pmux_pipe_if #(.WIDTH(8), .CHANNELS(8), .SEL_W(4)) b8 ();
  pmux_pipe_if #(.WIDTH(8), .CHANNELS(6), .SEL_W(4)) b6 ();

`ifdef PMUX_PIPE_STATS_EN
  logic [15:0] acc8, miss8, acc6, miss6;
`endif

  pmux_pipe #(.WIDTH(8), .CHANNELS(8), .SEL_W(4), .GROUP(2)) u_dut8 (
    .clk(clk), .rst(rst), .bus(b8.slave)
`ifdef PMUX_PIPE_STATS_EN
    , .acc_cnt(acc8), .miss_cnt(miss8)
`endif
  );

  pmux_pipe #(.WIDTH(8), .CHANNELS(6), .SEL_W(4), .GROUP(2)) u_dut6 (
    .clk(clk), .rst(rst), .bus(b6.slave)
`ifdef PMUX_PIPE_STATS_EN
    , .acc_cnt(acc6), .miss_cnt(miss6)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b8.in_valid = 1'b0; b8.mode = 1'b0; b8.sel = 4'd0; b8.req = 8'h00; b8.out_ready = 1'b1;
    b6.in_valid = 1'b0; b6.mode = 1'b0; b6.sel = 4'd0; b6.req = 6'h00; b6.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) b8.d[i*8 +: 8] = 8'h10 + 8'(i);
    for (int i = 0; i < 6; i++) b6.d[i*8 +: 8] = 8'h20 + 8'(i);
    cyc();
    cyc();
    checks++;
    if ({b8.out_valid, b8.y, b8.y_chan, b8.miss} !== 13'd0) begin
      errors++; $display("FAIL reset_state got v=%b y=%h ch=%0d m=%b expected all zero", b8.out_valid, b8.y, b8.y_chan, b8.miss);
    end
    checks++;
    if (b8.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b expected 1", b8.in_ready);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_indexed_sweep();
    logic [7:0] exp_y;
    logic [2:0] exp_c;
    b8.mode = 1'b0; b8.out_ready = 1'b1; b8.in_valid = 1'b1;
    for (int s = 0; s < 16; s++) begin
      b8.sel = 4'(s);
      cyc();
      exp_y = 8'h10 + 8'(s / 2);
      exp_c = 3'(s / 2);
      checks++;
      if (b8.out_valid !== 1'b1 || b8.y !== exp_y || b8.y_chan !== exp_c || b8.miss !== 1'b0) begin
        errors++;
        $display("FAIL sweep sel=%0d got v=%b y=%h ch=%0d m=%b expected v=1 y=%h ch=%0d m=0",
                 s, b8.out_valid, b8.y, b8.y_chan, b8.miss, exp_y, exp_c);
      end
    end
    b8.in_valid = 1'b0;
    cyc();
    checks++;
    if (b8.out_valid !== 1'b0 || b8.y !== 8'h17) begin
      errors++; $display("FAIL sweep_drain got v=%b y=%h expected v=0 y=17", b8.out_valid, b8.y);
    end
  endtask

  task automatic test_out_of_range();
    b6.mode = 1'b0; b6.out_ready = 1'b1; b6.in_valid = 1'b1;
    b6.sel = 4'd11;
    cyc();
    checks++;
    if (b6.y !== 8'h25 || b6.y_chan !== 3'd5 || b6.miss !== 1'b0 || b6.out_valid !== 1'b1) begin
      errors++; $display("FAIL oor_sel11 got y=%h ch=%0d m=%b expected y=25 ch=5 m=0", b6.y, b6.y_chan, b6.miss);
    end
    b6.sel = 4'd13;
    cyc();
    checks++;
    if (b6.y !== 8'h00 || b6.y_chan !== 3'd0 || b6.miss !== 1'b1 || b6.out_valid !== 1'b1) begin
      errors++; $display("FAIL oor_sel13 got y=%h ch=%0d m=%b expected y=00 ch=0 m=1", b6.y, b6.y_chan, b6.miss);
    end
    b6.sel = 4'd12;
    cyc();
    checks++;
    if (b6.y !== 8'h00 || b6.miss !== 1'b1) begin
      errors++; $display("FAIL oor_sel12 got y=%h m=%b expected y=00 m=1", b6.y, b6.miss);
    end
    b6.in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_priority();
    logic [7:0] reqs [4];
    logic [7:0] ey   [4];
    logic [2:0] ec   [4];
    logic       em   [4];
    reqs[0] = 8'b0010_1000; ey[0] = 8'h13; ec[0] = 3'd3; em[0] = 1'b0;
    reqs[1] = 8'h80;        ey[1] = 8'h17; ec[1] = 3'd7; em[1] = 1'b0;
    reqs[2] = 8'h00;        ey[2] = 8'h00; ec[2] = 3'd0; em[2] = 1'b1;
    reqs[3] = 8'hFF;        ey[3] = 8'h10; ec[3] = 3'd0; em[3] = 1'b0;
    b8.mode = 1'b1; b8.sel = 4'd13; b8.out_ready = 1'b1; b8.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b8.req = reqs[k];
      cyc();
      checks++;
      if (b8.y !== ey[k] || b8.y_chan !== ec[k] || b8.miss !== em[k] || b8.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL prio req=%b got y=%h ch=%0d m=%b expected y=%h ch=%0d m=%b",
                 reqs[k], b8.y, b8.y_chan, b8.miss, ey[k], ec[k], em[k]);
      end
    end
    b8.in_valid = 1'b0; b8.mode = 1'b0; b8.req = 8'h00;
    cyc();
  endtask

  task automatic test_backpressure();
    b8.mode = 1'b0; b8.out_ready = 1'b1; b8.in_valid = 1'b1; b8.sel = 4'd2;
    cyc();
    checks++;
    if (b8.out_valid !== 1'b1 || b8.y !== 8'h11) begin
      errors++; $display("FAIL bp_load_a got v=%b y=%h expected v=1 y=11", b8.out_valid, b8.y);
    end
    b8.out_ready = 1'b0; b8.sel = 4'd8;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (b8.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_in_ready cycle=%0d got %b expected 0", k, b8.in_ready);
      end
      cyc();
      checks++;
      if (b8.out_valid !== 1'b1 || b8.y !== 8'h11 || b8.y_chan !== 3'd1) begin
        errors++; $display("FAIL bp_hold cycle=%0d got v=%b y=%h ch=%0d expected v=1 y=11 ch=1", k, b8.out_valid, b8.y, b8.y_chan);
      end
    end
    b8.out_ready = 1'b1;
    #1;
    checks++;
    if (b8.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready got %b expected 1", b8.in_ready);
    end
    cyc();
    checks++;
    if (b8.out_valid !== 1'b1 || b8.y !== 8'h14 || b8.y_chan !== 3'd4) begin
      errors++; $display("FAIL bp_b_out got v=%b y=%h ch=%0d expected v=1 y=14 ch=4", b8.out_valid, b8.y, b8.y_chan);
    end
    b8.in_valid = 1'b0;
    cyc();
    checks++;
    if (b8.out_valid !== 1'b0 || b8.y !== 8'h14) begin
      errors++; $display("FAIL bp_no_dup got v=%b y=%h expected v=0 y=14", b8.out_valid, b8.y);
    end
  endtask

  task automatic test_async_reset();
    b8.mode = 1'b0; b8.out_ready = 1'b1; b8.in_valid = 1'b1; b8.sel = 4'd3;
    cyc();
    b8.in_valid = 1'b0; b8.out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({b8.out_valid, b8.y, b8.y_chan, b8.miss} !== 13'd0) begin
      errors++; $display("FAIL async_rst got v=%b y=%h ch=%0d m=%b expected all zero", b8.out_valid, b8.y, b8.y_chan, b8.miss);
    end
    cyc();
    rst = 1'b0;
    b8.out_ready = 1'b1; b8.in_valid = 1'b1; b8.sel = 4'd10;
    cyc();
    checks++;
    if (b8.out_valid !== 1'b1 || b8.y !== 8'h15 || b8.y_chan !== 3'd5) begin
      errors++; $display("FAIL post_rst_first got v=%b y=%h ch=%0d expected v=1 y=15 ch=5", b8.out_valid, b8.y, b8.y_chan);
    end
    b8.in_valid = 1'b0;
    cyc();
  endtask

`ifdef PMUX_PIPE_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (acc8 !== 16'd0 || miss8 !== 16'd0) begin
      errors++; $display("FAIL stats_reset got acc=%h miss=%h expected 0 0", acc8, miss8);
    end
    b8.mode = 1'b1; b8.out_ready = 1'b1; b8.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      b8.req = (k == 2 || k == 5 || k == 9) ? 8'h00 : 8'h04;
      cyc();
    end
    b8.in_valid = 1'b0;
    cyc();
    checks++;
    if (acc8 !== 16'd10 || miss8 !== 16'd3) begin
      errors++; $display("FAIL stats_10_3 got acc=%0d miss=%0d expected 10 3", acc8, miss8);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    b8.req = 8'h01; b8.in_valid = 1'b1;
    for (int k = 0; k < 65534; k++) cyc();
    b8.in_valid = 1'b0;
    cyc();
    checks++;
    if (acc8 !== 16'hFFFE) begin
      errors++; $display("FAIL stats_preload got acc=%h expected fffe", acc8);
    end
    b8.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    b8.in_valid = 1'b0;
    cyc();
    checks++;
    if (acc8 !== 16'hFFFF || miss8 !== 16'h0000) begin
      errors++; $display("FAIL stats_saturate got acc=%h miss=%h expected ffff 0000", acc8, miss8);
    end
    b8.mode = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_indexed_sweep();
    test_out_of_range();
    test_priority();
    test_backpressure();
    test_async_reset();
`ifdef PMUX_PIPE_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
